// File: rtl/issue_scheduler.sv
// Dual-issue scheduler for an in-order RV32 pair (InstrA older, InstrB younger).
// Load-use scoreboard, flush handling, fetch PC/increment control, perf counters.
module issue_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] InstrA,
    input  logic [DATA_WIDTH-1:0] InstrB,
    input  logic                  exec_ready,
    input  logic                  flush,
    output logic                  PCSrc,
    output logic                  IncrSrc,
    output logic                  issue_a,
    output logic                  issue_b,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  dual_cnt
);

    localparam int SBW = $clog2(LOAD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP_R || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return !(op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic is_ctl(input logic [6:0] op);
        return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [SBW-1:0]       sb_q [32];
    logic [SBW-1:0]       sb_d [32];
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] dual_cnt_q, dual_cnt_d;

    logic [6:0] op_a, op_b;
    logic [4:0] rd_a, rs1_a, rs2_a;
    logic [4:0] rd_b, rs1_b, rs2_b;
    logic       busy_a, busy_b, raw, waw, mem2, ctl;
    logic       pair_conflict, ld_a, ld_b;
    logic       unused_bits;

    assign op_a  = InstrA[6:0];
    assign rd_a  = InstrA[11:7];
    assign rs1_a = InstrA[19:15];
    assign rs2_a = InstrA[24:20];
    assign op_b  = InstrB[6:0];
    assign rd_b  = InstrB[11:7];
    assign rs1_b = InstrB[19:15];
    assign rs2_b = InstrB[24:20];

    assign unused_bits = ^{InstrA[DATA_WIDTH-1:25], InstrA[14:12],
                           InstrB[DATA_WIDTH-1:25], InstrB[14:12]};

    // Hazard detection: busy sources and same-cycle pair conflicts
    always_comb begin
        busy_a = (uses_rs1(op_a) && rs1_a != 5'd0 && sb_q[rs1_a] != '0)
              || (uses_rs2(op_a) && rs2_a != 5'd0 && sb_q[rs2_a] != '0);
        busy_b = (uses_rs1(op_b) && rs1_b != 5'd0 && sb_q[rs1_b] != '0)
              || (uses_rs2(op_b) && rs2_b != 5'd0 && sb_q[rs2_b] != '0);
        raw  = writes_rd(op_a) && rd_a != 5'd0
            && ((uses_rs1(op_b) && rs1_b == rd_a)
             || (uses_rs2(op_b) && rs2_b == rd_a));
        waw  = writes_rd(op_a) && writes_rd(op_b)
            && rd_a != 5'd0 && rd_a == rd_b;
        mem2 = (op_a == OP_LOAD || op_a == OP_STORE)
            && (op_b == OP_LOAD || op_b == OP_STORE);
        ctl  = is_ctl(op_a) || is_ctl(op_b);
        pair_conflict = raw || waw || mem2 || ctl;
    end

    // Issue decisions and fetch control; flush overrides everything
    always_comb begin
        issue_a = (state_q == S_RUN) && !flush && exec_ready && !busy_a;
        issue_b = issue_a && !busy_b && !pair_conflict;
        IncrSrc = issue_b;
        if (state_q == S_FLUSH || (state_q == S_RUN && flush)) begin
            PCSrc = 1'b0;
        end else begin
            PCSrc = !issue_a;
        end
        ld_a = issue_a && op_a == OP_LOAD && rd_a != 5'd0;
        ld_b = issue_b && op_b == OP_LOAD && rd_b != 5'd0;
    end

    // Control FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_FLUSH;
            S_FLUSH: state_d = flush ? S_FLUSH : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Scoreboard: issued loads arm their rd, all others count down
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            sb_d[r] = sb_q[r];
            if (r == 0) begin
                sb_d[r] = '0;
            end else if (ld_b && rd_b == 5'(r)) begin
                sb_d[r] = SBW'(LOAD_LAT);
            end else if (ld_a && rd_a == 5'(r)) begin
                sb_d[r] = SBW'(LOAD_LAT);
            end else if (sb_q[r] != '0) begin
                sb_d[r] = sb_q[r] - SBW'(1);
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        dual_cnt_d  = dual_cnt_q;
        if (state_q == S_RUN && !issue_a && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (issue_a && issue_b && dual_cnt_q != '1) begin
            dual_cnt_d = dual_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
            dual_cnt_q  <= '0;
            for (int r = 0; r < 32; r++) begin
                sb_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            dual_cnt_q  <= dual_cnt_d;
            sb_q        <= sb_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dual_cnt  = dual_cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random pairs
// checked against a cycle-timestamp reference model.
module tb_issue_scheduler;

    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic clk = 1'b0;
    logic rst, exec_ready, flush;
    logic [DW-1:0] instr_a, instr_b;
    logic pc_src, incr_src, issue_a, issue_b;
    logic [CW-1:0] stall_cnt, dual_cnt;

    always #5 clk = ~clk;

    issue_scheduler #(.DATA_WIDTH(DW), .LOAD_LAT(LAT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .InstrA(instr_a), .InstrB(instr_b),
        .exec_ready(exec_ready), .flush(flush), .PCSrc(pc_src),
        .IncrSrc(incr_src), .issue_a(issue_a), .issue_b(issue_b),
        .stall_cnt(stall_cnt), .dual_cnt(dual_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 run, 2 flush; ready_at = first cycle reg is free
    int m_state;
    int cyc;
    int ready_at [32];
    int m_stall, m_dual;
    logic [3:0] obs;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
        input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
    endfunction

    function automatic bit reads1(input logic [31:0] w);
        return !(w[6:0] inside {LUI, AUI, JAL});
    endfunction
    function automatic bit reads2(input logic [31:0] w);
        return w[6:0] inside {OPR, ST, BR};
    endfunction
    function automatic bit writes(input logic [31:0] w);
        return !(w[6:0] inside {ST, BR});
    endfunction

    function automatic bit reg_busy(input int r);
        return r != 0 && cyc < ready_at[r];
    endfunction

    function automatic bit waits(input logic [31:0] w);
        return (reads1(w) && reg_busy(int'(w[19:15])))
            || (reads2(w) && reg_busy(int'(w[24:20])));
    endfunction

    function automatic bit conflict(input logic [31:0] a, input logic [31:0] b);
        int d;
        bit dep, same, mem, ctl;
        d    = int'(a[11:7]);
        dep  = writes(a) && d != 0
            && ((reads1(b) && int'(b[19:15]) == d)
             || (reads2(b) && int'(b[24:20]) == d));
        same = writes(a) && writes(b) && d != 0 && d == int'(b[11:7]);
        mem  = a[6:0] inside {LD, ST} && b[6:0] inside {LD, ST};
        ctl  = a[6:0] inside {BR, JAL, JLR} || b[6:0] inside {BR, JAL, JLR};
        return dep || same || mem || ctl;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_stall = 0;
        m_dual  = 0;
        foreach (ready_at[i]) ready_at[i] = 0;
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input bit er, input bit fl, input bit rs);
        bit ea, eb, ep;
        instr_a = a;
        instr_b = b;
        exec_ready = er;
        flush = fl;
        rst = rs;
        #2;
        ea = m_state == 1 && !fl && er && !waits(a);
        eb = ea && !waits(b) && !conflict(a, b);
        if (m_state == 2 || (m_state == 1 && fl)) ep = 1'b0;
        else ep = !ea;
        obs = {issue_a, issue_b, pc_src, incr_src};
        check("ctl", 64'(obs), 64'({ea, eb, ep, eb}));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("dual_cnt", 64'(dual_cnt), 64'(m_dual));
        if (rs) begin
            model_reset();
        end else begin
            if (m_state == 1 && !ea && m_stall < CMAX) m_stall++;
            if (ea && eb && m_dual < CMAX) m_dual++;
            if (ea && a[6:0] == LD && a[11:7] != 0)
                ready_at[a[11:7]] = cyc + LAT + 1;
            if (eb && b[6:0] == LD && b[11:7] != 0)
                ready_at[b[11:7]] = cyc + LAT + 1;
            if (m_state == 0) m_state = 1;
            else m_state = fl ? 2 : 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{LUI, AUI, JAL, JLR, BR, LD, ST, OPR, OPI, LD};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    logic [31:0] nop;
    int s0;

    initial begin
        nop = mk(OPI, 0, 0, 0);
        cyc = 0;
        rst = 1'b1;
        exec_ready = 1'b0;
        flush = 1'b0;
        instr_a = '0;
        instr_b = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // reset state, then both addi issue together
        step(mk(OPI, 1, 0, 0), mk(OPI, 2, 0, 0), 1, 0, 0);
        check("idle_out", 64'(obs), 64'(4'b0010));
        step(mk(OPI, 1, 0, 0), mk(OPI, 2, 0, 0), 1, 0, 0);
        check("dual_pair", 64'(obs), 64'(4'b1101));
        check("dual_one", 64'(dual_cnt), 64'd1);

        // RAW inside the pair
        step(mk(OPI, 1, 0, 0), mk(OPR, 3, 1, 1), 1, 0, 0);
        check("raw_pair", 64'(obs), 64'(4'b1000));

        // load-use stall for LOAD_LAT cycles
        step(mk(LD, 5, 0, 0), nop, 1, 0, 0);
        s0 = int'(stall_cnt);
        step(mk(OPR, 6, 5, 0), nop, 1, 0, 0);
        check("lu_stall1", 64'(obs), 64'(4'b0010));
        step(mk(OPR, 6, 5, 0), nop, 1, 0, 0);
        check("lu_stall2", 64'(obs), 64'(4'b0010));
        step(mk(OPR, 6, 5, 0), nop, 1, 0, 0);
        check("lu_go", 64'(obs), 64'(4'b1101));
        check("lu_cnt", 64'(int'(stall_cnt) - s0), 64'd2);

        // two memory ops, and a branch, single issue
        step(mk(LD, 1, 0, 0), mk(ST, 0, 0, 2), 1, 0, 0);
        check("mem_pair", 64'(obs), 64'(4'b1000));
        step(mk(BR, 0, 0, 0), mk(OPI, 7, 0, 0), 1, 0, 0);
        check("br_pair", 64'(obs), 64'(4'b1000));

        // flush: blocked this cycle and the next, then resume
        step(mk(OPI, 1, 0, 0), mk(OPI, 2, 0, 0), 1, 1, 0);
        check("flush_now", 64'(obs), 64'(4'b0000));
        step(mk(OPI, 1, 0, 0), mk(OPI, 2, 0, 0), 1, 0, 0);
        check("flush_st", 64'(obs), 64'(4'b0000));
        step(mk(OPI, 1, 0, 0), mk(OPI, 2, 0, 0), 1, 0, 0);
        check("flush_end", 64'(obs), 64'(4'b1101));

        // exec not ready long enough to saturate stall_cnt
        for (int i = 0; i < CMAX + 3; i++) step(nop, nop, 0, 0, 0);
        check("sat_cnt", 64'(stall_cnt), 64'(CMAX));
        step(nop, nop, 0, 0, 0);
        check("sat_out", 64'(obs), 64'(4'b0010));
        check("sat_hold", 64'(stall_cnt), 64'(CMAX));

        // reset with a load in flight
        step(mk(LD, 4, 0, 0), nop, 1, 0, 0);
        step(mk(OPR, 8, 4, 0), nop, 1, 0, 1);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_dual", 64'(dual_cnt), 64'd0);
        step(mk(OPR, 8, 4, 0), nop, 1, 0, 0);
        check("rst_idle", 64'(obs), 64'(4'b0010));
        step(mk(OPR, 8, 4, 0), nop, 1, 0, 0);
        check("rst_nohaz", 64'(obs), 64'(4'b1101));

        // random pairs against the model
        for (int i = 0; i < 3000; i++) begin
            step(rand_instr(), rand_instr(),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 149) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set instruction word width.
REQ-002 Parameter LOAD_LAT, default 2, SHALL set the load-use latency in cycles (range 1..7).
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the performance-counter width.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be synchronous, active-high reset.
REQ-006 Port InstrA, input, DATA_WIDTH, SHALL be the older instruction fetched at PC.
REQ-007 Port InstrB, input, DATA_WIDTH, SHALL be the younger instruction fetched at PC+4.
REQ-008 Port exec_ready, input, 1, high SHALL mean execute accepts an issue this cycle.
REQ-009 Port flush, input, 1, high SHALL mean a taken branch/jump was resolved and fetched words are stale.
REQ-010 Port PCSrc, output, 1, SHALL drive the fetch PC mux: 0 = advance, 1 = hold PC.
REQ-011 Port IncrSrc, output, 1, SHALL drive the increment mux: 0 = +4, 1 = +8.
REQ-012 Port issue_a, output, 1, high SHALL mean InstrA is issued this cycle.
REQ-013 Port issue_b, output, 1, high SHALL mean InstrB is issued this cycle.
REQ-014 Port stall_cnt, output, CNT_WIDTH, SHALL count cycles in RUN with issue_a low.
REQ-015 Port dual_cnt, output, CNT_WIDTH, SHALL count cycles with issue_a and issue_b both high.

Function
REQ-016 Decode: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20] for both words.
REQ-017 rs1 read by all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111.
REQ-018 rs2 read only by R 0110011, store 0100011, branch 1100011.
REQ-019 rd written by all opcodes except store and branch.
REQ-020 Register x0 SHALL never cause a hazard or scoreboard entry.
REQ-021 Scoreboard: one down-counter per register x1..x31, width clog2(LOAD_LAT+1).
REQ-022 When an issued load (0000011) writes rd != 0, counter[rd] SHALL load LOAD_LAT; otherwise each nonzero counter SHALL decrement by 1 per cycle.
REQ-023 If issue_a and issue_b both issue loads, only B's rd is set; issue rules make equal rd impossible.
REQ-024 A register SHALL be busy while its counter is nonzero.
REQ-025 FSM states IDLE, RUN, FLUSH; IDLE->RUN after the first cycle with rst low.
REQ-026 RUN->FLUSH when flush=1; FLUSH->RUN after exactly one cycle, unless flush=1 again (stay FLUSH).
REQ-027 flush SHALL take priority over all issue decisions in the same cycle.
REQ-028 issue_a = state RUN and flush=0 and exec_ready=1 and no source of A busy.
REQ-029 issue_b = issue_a and no source of B busy and no pair conflict.
REQ-030 Pair conflict: B reads A's rd (rd != 0); A and B write the same rd (!= 0); both load/store; A or B is branch/JAL/JALR.
REQ-031 Outputs SHALL be combinational from InstrA/InstrB/inputs and registered state, same cycle.
REQ-032 PCSrc = not issue_a in IDLE and RUN; PCSrc = 0 in FLUSH (external redirect owns PC).
REQ-033 IncrSrc = issue_b; IncrSrc = 0 whenever issue_a is 0.
REQ-034 Counters SHALL saturate at all-ones and never wrap.
REQ-035 Scoreboard SHALL keep counting down in FLUSH and during exec_ready stalls (loads already issued stay in flight).

Reset
REQ-036 On rst=1 at a clock edge: state=IDLE, all scoreboard counters=0, stall_cnt=0, dual_cnt=0.
REQ-037 While state=IDLE: issue_a=0, issue_b=0, PCSrc=1, IncrSrc=0.
REQ-038 rst asserted mid-operation (any state, loads in flight) SHALL apply REQ-036 on that edge with no pending effect after.

Verification
REQ-039 Reset then A=addi x1,x0,1, B=addi x2,x0,2, exec_ready=1 -> IDLE cycle PCSrc=1; next cycle issue_a=1, issue_b=1, IncrSrc=1, dual_cnt=1.
REQ-040 A=addi x1,x0,1, B=add x3,x1,x1 -> issue_a=1, issue_b=0, IncrSrc=0, PCSrc=0.
REQ-041 A=lw x5,0(x0) issued; next cycle A=add x6,x5,x0 -> issue_a=0, PCSrc=1 for 2 cycles (LOAD_LAT=2), stall_cnt=2, then issues.
REQ-042 A=lw x1, B=sw x2 -> single issue only; A=beq x0,x0 -> issue_b=0.
REQ-043 flush=1 in RUN with independent pair -> issue_a=issue_b=0, PCSrc=0 that cycle and next (FLUSH); issue resumes cycle after.
REQ-044 exec_ready=0 for 3 cycles with stall_cnt=all-ones -> PCSrc=1, no issue, stall_cnt stays all-ones; rst mid-sequence -> counters 0, state IDLE.
